// File: rtl/if_fetch_stage.sv
// if_fetch_stage: VLIW bundle fetch into IF/ID through a fetch buffer, 3 deep under IF_PREFETCH_BUF_EN, otherwise 1.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p1_pipeline_stall,
    input  logic        IF_flush,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] mem_shiftedSext8_branchOffset,
    input  logic [31:0] mem_shiftedSext11_jumpOffset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [15:0] p1_aluInstr,
    output logic [15:0] p1_memInstr,
    output logic [31:0] p1_pc,
    output logic        p1_valid
);
`ifdef IF_PREFETCH_BUF_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d, hold_addr_q, hold_addr_d;
    logic [DEPTH*64-1:0] buf_q, buf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         p1_alu_q, p1_alu_d, p1_mem_q, p1_mem_d;
    logic [31:0]         p1_pc_q, p1_pc_d;
    logic                p1_valid_q, p1_valid_d;
    logic                redirect, resp, bypass, pop, push, hold, load;
    logic [31:0]         target;
    logic [63:0]         head;

    always_comb begin
        redirect = p1_valid_q & ~p1_pipeline_stall & (pcSrc == 2'b01 || pcSrc == 2'b10);
        target = (p1_pc_q + 32'd4 + (pcSrc == 2'b01 ? mem_shiftedSext8_branchOffset
                                                     : mem_shiftedSext11_jumpOffset)) & ~32'd3;
        resp = (state_q == REQ) & imem_ready;
        hold = p1_pipeline_stall & ~IF_flush;
        pop = ~redirect & ~IF_flush & ~p1_pipeline_stall & (cnt_q != '0);
        bypass = resp & ~redirect & ~IF_flush & ~p1_pipeline_stall & (cnt_q == '0);
        push = resp & ~redirect & ~bypass;
        imem_req = state_q != IDLE;
        imem_addr = state_q == DISCARD ? hold_addr_q : fetch_pc_q;
        hold_addr_d = state_q == DISCARD ? hold_addr_q : fetch_pc_q;
        fetch_pc_d = redirect ? target : resp ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // Pop shifts the head out; a push lands just past the surviving entries.
        buf_d = pop ? buf_q >> 64 : buf_q;
        cnt_d = cnt_q - CW'(pop);
        if (push)
            buf_d[64*int'(cnt_d) +: 64] = {fetch_pc_q, imem_rdata};
        cnt_d = redirect ? '0 : cnt_d + CW'(push);
        state_d = redirect ? ((state_q != IDLE && !imem_ready) ? DISCARD : REQ)
                : state_q == DISCARD ? (imem_ready ? REQ : DISCARD)
                : (state_q == REQ && !imem_ready) ? REQ
                : int'(cnt_d) < DEPTH ? REQ : IDLE;
        head = pop ? buf_q[63:0] : {fetch_pc_q, imem_rdata};
        load = pop | bypass;
        p1_alu_d = hold ? p1_alu_q : load ? head[15:0] : 16'h0000;
        p1_mem_d = hold ? p1_mem_q : load ? head[31:16] : 16'h0000;
        p1_pc_d = load ? head[63:32] : p1_pc_q;
        p1_valid_d = hold ? p1_valid_q : load;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= RESET_PC;
            buf_q       <= '0;
            cnt_q       <= '0;
            p1_alu_q    <= '0;
            p1_mem_q    <= '0;
            p1_pc_q     <= RESET_PC;
            p1_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            p1_alu_q    <= p1_alu_d;
            p1_mem_q    <= p1_mem_d;
            p1_pc_q     <= p1_pc_d;
            p1_valid_q  <= p1_valid_d;
        end
    end

    assign p1_aluInstr = p1_alu_q;
    assign p1_memInstr = p1_mem_q;
    assign p1_pc       = p1_pc_q;
    assign p1_valid    = p1_valid_q;
endmodule
